// File: rtl/cdb_arbiter_pkg.sv
// Common data bus widths and the lane bundle shared by the
// arbiter, the ROB completion port and the RS wakeup logic.
package cdb_pkg;

  localparam int ROB_IDX_W = 5;
  localparam int TAG_W     = 6;
  localparam int DATA_W    = 64;

  typedef struct packed {
    logic                 rdy;
    logic [ROB_IDX_W-1:0] robidx;
    logic [TAG_W-1:0]     tag;
    logic [DATA_W-1:0]    data;
  } cdb_lane_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU completion requests on one side, the two registered
// CDB lanes towards the ROB and wakeup logic on the other.
interface cdb_arbiter_if
  import cdb_pkg::*;
#(
  parameter int NUM_FU = 4
) ();

  logic                        flush;
  logic [NUM_FU-1:0]           fu_req;
  logic [NUM_FU*ROB_IDX_W-1:0] fu_robidx;
  logic [NUM_FU*TAG_W-1:0]     fu_tag;
  logic [NUM_FU*DATA_W-1:0]    fu_data;
  logic [NUM_FU-1:0]           fu_grant;

  logic                        ex_cm_cdbA_rdy;
  logic                        ex_cm_cdbB_rdy;
  logic [ROB_IDX_W-1:0]        ex_cm_robAIdx;
  logic [ROB_IDX_W-1:0]        ex_cm_robBIdx;
  logic [TAG_W-1:0]            cdbA_tag;
  logic [TAG_W-1:0]            cdbB_tag;
  logic [DATA_W-1:0]           cdbA_data;
  logic [DATA_W-1:0]           cdbB_data;

  modport master (
    output flush, fu_req, fu_robidx, fu_tag, fu_data,
    input  fu_grant,
    input  ex_cm_cdbA_rdy, ex_cm_cdbB_rdy,
    input  ex_cm_robAIdx, ex_cm_robBIdx,
    input  cdbA_tag, cdbB_tag, cdbA_data, cdbB_data
  );

  modport slave (
    input  flush, fu_req, fu_robidx, fu_tag, fu_data,
    output fu_grant,
    output ex_cm_cdbA_rdy, ex_cm_cdbB_rdy,
    output ex_cm_robAIdx, ex_cm_robBIdx,
    output cdbA_tag, cdbB_tag, cdbA_data, cdbB_data
  );

endinterface

// File: rtl/cdb_arbiter_rr_pick2.sv
// Circular first-two-set finder: scans req starting at ptr
// and returns the first and second set bits as one-hots.
module rr_pick2 #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  first,
  output logic [N-1:0]  second,
  output logic          first_vld,
  output logic          second_vld
);

  localparam logic [PW:0] NW = (PW+1)'(N);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  always_comb begin
    first      = '0;
    second     = '0;
    first_vld  = 1'b0;
    second_vld = 1'b0;
    sum        = '0;
    idx        = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + k[PW:0];
      if (sum >= NW) sum = sum - NW;
      idx = sum[PW-1:0];
      if (req[idx]) begin
        if (!first_vld) begin
          first[idx] = 1'b1;
          first_vld  = 1'b1;
        end else if (!second_vld) begin
          second[idx] = 1'b1;
          second_vld  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Two-lane CDB arbiter: fixed-priority non-stallable FUs,
// round-robin stallable FUs, winners registered onto lanes A/B.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int                NUM_FU       = 4,
  parameter logic [NUM_FU-1:0] NOSTALL_MASK =
    {{(NUM_FU-1){1'b0}}, 1'b1}
) (
  input logic         clock,
  input logic         reset,
  cdb_arbiter_if.slave bus
);

  localparam int PW = $clog2(NUM_FU);

  logic [NUM_FU-1:0] ns0, ns1, st0, st1, a_oh, b_oh;
  logic              ns_v0, ns_v1, st_v0, st_v1;
  logic              a_vld, b_vld, go, st_use0, st_use1;
  logic [PW-1:0]     rr_ptr, rr_nxt, last;
  cdb_lane_t         lane_a, lane_b, pay_a, pay_b;

  function automatic logic [PW-1:0] enc(
    input logic [NUM_FU-1:0] oh
  );
    enc = '0;
    for (int i = 0; i < NUM_FU; i++)
      if (oh[i]) enc = i[PW-1:0];
  endfunction

  function automatic cdb_lane_t pick(
    input logic [NUM_FU-1:0]           oh,
    input logic [NUM_FU*ROB_IDX_W-1:0] idx,
    input logic [NUM_FU*TAG_W-1:0]     tag,
    input logic [NUM_FU*DATA_W-1:0]    data
  );
    pick = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (oh[i]) begin
        pick.robidx = pick.robidx | idx[i*ROB_IDX_W +: ROB_IDX_W];
        pick.tag    = pick.tag | tag[i*TAG_W +: TAG_W];
        pick.data   = pick.data | data[i*DATA_W +: DATA_W];
      end
    end
    pick.rdy = |oh;
  endfunction

  rr_pick2 #(.N(NUM_FU), .PW(PW)) u_ns (
    .req        (bus.fu_req & NOSTALL_MASK),
    .ptr        ('0),
    .first      (ns0),
    .second     (ns1),
    .first_vld  (ns_v0),
    .second_vld (ns_v1)
  );

  rr_pick2 #(.N(NUM_FU), .PW(PW)) u_st (
    .req        (bus.fu_req & ~NOSTALL_MASK),
    .ptr        (rr_ptr),
    .first      (st0),
    .second     (st1),
    .first_vld  (st_v0),
    .second_vld (st_v1)
  );

  // Stallable winners only fill lanes left free by non-stallables.
  always_comb begin
    go      = reset & ~bus.flush;
    a_oh    = ns_v0 ? ns0 : st0;
    a_vld   = ns_v0 | st_v0;
    st_use0 = st_v0 & ~ns_v1;
    st_use1 = st_v1 & ~ns_v0;
    b_oh    = '0;
    b_vld   = 1'b0;
    unique case (1'b1)
      ns_v1: begin
        b_oh  = ns1;
        b_vld = 1'b1;
      end
      (ns_v0 & ~ns_v1): begin
        b_oh  = st0;
        b_vld = st_v0;
      end
      (~ns_v0): begin
        b_oh  = st1;
        b_vld = st_v1;
      end
      default: b_oh = '0;
    endcase
    last   = st_use1 ? enc(st1) : enc(st0);
    rr_nxt = (last == PW'(NUM_FU-1)) ? '0 : last + 1'b1;
    pay_a  = pick(a_oh, bus.fu_robidx, bus.fu_tag, bus.fu_data);
    pay_b  = pick(b_oh, bus.fu_robidx, bus.fu_tag, bus.fu_data);
  end

  assign bus.fu_grant = (a_oh | b_oh) & {NUM_FU{go}};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lane_a <= '0;
      lane_b <= '0;
      rr_ptr <= '0;
    end else if (bus.flush) begin
      lane_a.rdy <= 1'b0;
      lane_b.rdy <= 1'b0;
      rr_ptr     <= '0;
    end else begin
      if (a_vld) lane_a <= pay_a;
      else       lane_a.rdy <= 1'b0;
      if (b_vld) lane_b <= pay_b;
      else       lane_b.rdy <= 1'b0;
      if (st_use0) rr_ptr <= rr_nxt;
    end
  end

  assign bus.ex_cm_cdbA_rdy = lane_a.rdy;
  assign bus.ex_cm_cdbB_rdy = lane_b.rdy;
  assign bus.ex_cm_robAIdx  = lane_a.robidx;
  assign bus.ex_cm_robBIdx  = lane_b.robidx;
  assign bus.cdbA_tag       = lane_a.tag;
  assign bus.cdbB_tag       = lane_b.tag;
  assign bus.cdbA_data      = lane_a.data;
  assign bus.cdbB_data      = lane_b.data;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench: dut0 has no non-stallable FUs, dut1 has FU0
// non-stallable; both share clock and reset.
module tb_cdb_arbiter;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  cdb_arbiter_if #(.NUM_FU(4)) bus0 ();
  cdb_arbiter_if #(.NUM_FU(4)) bus1 ();

  cdb_arbiter #(.NUM_FU(4), .NOSTALL_MASK(4'b0000)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  cdb_arbiter #(.NUM_FU(4), .NOSTALL_MASK(4'b0001)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock)
    if (reset)
      assert ($countones(bus1.fu_req & 4'b0001) <= 2)
        else $error("illegal non-stallable request count");

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic load0(input int i, input logic [4:0] idx,
                       input logic [5:0] tag, input logic [63:0] d);
    bus0.fu_robidx[i*5 +: 5] = idx;
    bus0.fu_tag[i*6 +: 6]    = tag;
    bus0.fu_data[i*64 +: 64] = d;
  endtask

  task automatic load1(input int i, input logic [4:0] idx,
                       input logic [5:0] tag, input logic [63:0] d);
    bus1.fu_robidx[i*5 +: 5] = idx;
    bus1.fu_tag[i*6 +: 6]    = tag;
    bus1.fu_data[i*64 +: 64] = d;
  endtask

  task automatic flush_both;
    bus0.fu_req = '0;
    bus1.fu_req = '0;
    bus0.flush  = 1'b1;
    bus1.flush  = 1'b1;
    step();
    bus0.flush  = 1'b0;
    bus1.flush  = 1'b0;
  endtask

  task automatic test_reset;
    bus0.fu_req = 4'hF;
    bus1.fu_req = 4'hF;
    step();
    step();
    checks++; if (bus0.fu_grant !== 4'b0000) begin errors++; $display("FAIL rst_grant0 got %b want 0000", bus0.fu_grant); end
    checks++; if (bus1.fu_grant !== 4'b0000) begin errors++; $display("FAIL rst_grant1 got %b want 0000", bus1.fu_grant); end
    checks++; if (bus0.ex_cm_cdbA_rdy !== 1'b0 || bus0.ex_cm_cdbB_rdy !== 1'b0) begin errors++; $display("FAIL rst_rdy got %b%b want 00", bus0.ex_cm_cdbA_rdy, bus0.ex_cm_cdbB_rdy); end
    checks++; if (bus0.ex_cm_robAIdx !== 5'd0 || bus0.cdbA_tag !== 6'd0) begin errors++; $display("FAIL rst_idx_tag got %0d/%0d want 0/0", bus0.ex_cm_robAIdx, bus0.cdbA_tag); end
    checks++; if (bus1.cdbB_data !== 64'd0) begin errors++; $display("FAIL rst_data got %h want 0", bus1.cdbB_data); end
    reset = 1'b1;
    #1;
    checks++; if (bus0.fu_grant !== 4'b0011) begin errors++; $display("FAIL rel_grant0 got %b want 0011", bus0.fu_grant); end
    checks++; if (bus1.fu_grant !== 4'b0011) begin errors++; $display("FAIL rel_grant1 got %b want 0011", bus1.fu_grant); end
    step();
    checks++; if (bus0.ex_cm_cdbA_rdy !== 1'b1 || bus0.ex_cm_cdbB_rdy !== 1'b1) begin errors++; $display("FAIL rel_rdy got %b%b want 11", bus0.ex_cm_cdbA_rdy, bus0.ex_cm_cdbB_rdy); end
    checks++; if (dut1.rr_ptr !== 2'd2) begin errors++; $display("FAIL rel_ptr got %0d want 2", dut1.rr_ptr); end
    reset = 1'b0;
    #1;
    checks++; if (bus0.fu_grant !== 4'b0000) begin errors++; $display("FAIL midrst_grant got %b want 0000", bus0.fu_grant); end
    checks++; if (bus0.ex_cm_cdbA_rdy !== 1'b0) begin errors++; $display("FAIL midrst_rdy got %b want 0", bus0.ex_cm_cdbA_rdy); end
    checks++; if (dut1.rr_ptr !== 2'd0) begin errors++; $display("FAIL midrst_ptr got %0d want 0", dut1.rr_ptr); end
    bus0.fu_req = '0;
    bus1.fu_req = '0;
    reset = 1'b1;
    step();
  endtask

  task automatic test_single;
    load0(2, 5'd7, 6'd40, 64'hDEAD_BEEF_0000_0002);
    bus0.fu_req = 4'b0100;
    #1;
    checks++; if (bus0.fu_grant !== 4'b0100) begin errors++; $display("FAIL single_grant got %b want 0100", bus0.fu_grant); end
    step();
    bus0.fu_req = '0;
    checks++; if (bus0.ex_cm_cdbA_rdy !== 1'b1 || bus0.ex_cm_cdbB_rdy !== 1'b0) begin errors++; $display("FAIL single_rdy got %b%b want 10", bus0.ex_cm_cdbA_rdy, bus0.ex_cm_cdbB_rdy); end
    checks++; if (bus0.ex_cm_robAIdx !== 5'd7) begin errors++; $display("FAIL single_idx got %0d want 7", bus0.ex_cm_robAIdx); end
    checks++; if (bus0.cdbA_tag !== 6'd40) begin errors++; $display("FAIL single_tag got %0d want 40", bus0.cdbA_tag); end
    checks++; if (bus0.cdbA_data !== 64'hDEAD_BEEF_0000_0002) begin errors++; $display("FAIL single_data got %h want deadbeef00000002", bus0.cdbA_data); end
    step();
    checks++; if (bus0.ex_cm_cdbA_rdy !== 1'b0) begin errors++; $display("FAIL single_oneshot got %b want 0", bus0.ex_cm_cdbA_rdy); end
  endtask

  task automatic test_round_robin;
    logic [3:0] g;
    logic [4:0] ia;
    logic [1:0] p;
    flush_both();
    for (int i = 0; i < 4; i++) load0(i, 5'(10 + i), 6'(i), 64'(i));
    bus0.fu_req = 4'hF;
    for (int c = 0; c < 3; c++) begin
      g  = (c == 1) ? 4'b1100 : 4'b0011;
      ia = (c == 1) ? 5'd12 : 5'd10;
      p  = (c == 1) ? 2'd0 : 2'd2;
      #1;
      checks++; if (bus0.fu_grant !== g) begin errors++; $display("FAIL rr_grant c%0d got %b want %b", c, bus0.fu_grant, g); end
      step();
      checks++; if (bus0.ex_cm_robAIdx !== ia || bus0.ex_cm_robBIdx !== ia + 5'd1) begin errors++; $display("FAIL rr_idx c%0d got %0d/%0d want %0d/%0d", c, bus0.ex_cm_robAIdx, bus0.ex_cm_robBIdx, ia, ia + 5'd1); end
      checks++; if (bus0.ex_cm_cdbA_rdy !== 1'b1 || bus0.ex_cm_cdbB_rdy !== 1'b1) begin errors++; $display("FAIL rr_rdy c%0d got %b%b want 11", c, bus0.ex_cm_cdbA_rdy, bus0.ex_cm_cdbB_rdy); end
      checks++; if (dut0.rr_ptr !== p) begin errors++; $display("FAIL rr_ptr c%0d got %0d want %0d", c, dut0.rr_ptr, p); end
    end
    bus0.fu_req = '0;
  endtask

  task automatic test_nostall;
    flush_both();
    for (int i = 0; i < 4; i++) load1(i, 5'(20 + i), 6'(30 + i), 64'(100 + i));
    bus1.fu_req = 4'b0010;
    #1;
    checks++; if (bus1.fu_grant !== 4'b0010) begin errors++; $display("FAIL ns_pre_grant got %b want 0010", bus1.fu_grant); end
    step();
    checks++; if (dut1.rr_ptr !== 2'd2) begin errors++; $display("FAIL ns_pre_ptr got %0d want 2", dut1.rr_ptr); end
    bus1.fu_req = 4'b1111;
    #1;
    checks++; if (bus1.fu_grant !== 4'b0101) begin errors++; $display("FAIL ns_grant1 got %b want 0101", bus1.fu_grant); end
    step();
    checks++; if (bus1.ex_cm_robAIdx !== 5'd20 || bus1.ex_cm_robBIdx !== 5'd22) begin errors++; $display("FAIL ns_idx1 got %0d/%0d want 20/22", bus1.ex_cm_robAIdx, bus1.ex_cm_robBIdx); end
    checks++; if (bus1.cdbB_tag !== 6'd32 || bus1.cdbB_data !== 64'd102) begin errors++; $display("FAIL ns_payload1 got %0d/%0d want 32/102", bus1.cdbB_tag, bus1.cdbB_data); end
    checks++; if (dut1.rr_ptr !== 2'd3) begin errors++; $display("FAIL ns_ptr1 got %0d want 3", dut1.rr_ptr); end
    bus1.fu_req = 4'b1011;
    #1;
    checks++; if (bus1.fu_grant !== 4'b1001) begin errors++; $display("FAIL ns_grant2 got %b want 1001", bus1.fu_grant); end
    step();
    checks++; if (bus1.ex_cm_robAIdx !== 5'd20 || bus1.ex_cm_robBIdx !== 5'd23) begin errors++; $display("FAIL ns_idx2 got %0d/%0d want 20/23", bus1.ex_cm_robAIdx, bus1.ex_cm_robBIdx); end
    checks++; if (dut1.rr_ptr !== 2'd0) begin errors++; $display("FAIL ns_ptr_wrap got %0d want 0", dut1.rr_ptr); end
    bus1.fu_req = '0;
  endtask

  task automatic test_flush;
    load0(0, 5'd4, 6'd1, 64'd4);
    load0(1, 5'd5, 6'd2, 64'd5);
    load0(2, 5'd6, 6'd3, 64'd6);
    bus0.fu_req = 4'b0001;
    step();
    bus0.fu_req = 4'b0110;
    bus0.flush  = 1'b1;
    #1;
    checks++; if (bus0.fu_grant !== 4'b0000) begin errors++; $display("FAIL flush_grant got %b want 0000", bus0.fu_grant); end
    step();
    bus0.flush = 1'b0;
    checks++; if (bus0.ex_cm_cdbA_rdy !== 1'b0 || bus0.ex_cm_cdbB_rdy !== 1'b0) begin errors++; $display("FAIL flush_rdy got %b%b want 00", bus0.ex_cm_cdbA_rdy, bus0.ex_cm_cdbB_rdy); end
    checks++; if (dut0.rr_ptr !== 2'd0) begin errors++; $display("FAIL flush_ptr got %0d want 0", dut0.rr_ptr); end
    #1;
    checks++; if (bus0.fu_grant !== 4'b0110) begin errors++; $display("FAIL postflush_grant got %b want 0110", bus0.fu_grant); end
    step();
    bus0.fu_req = '0;
    checks++; if (bus0.ex_cm_robAIdx !== 5'd5 || bus0.ex_cm_robBIdx !== 5'd6) begin errors++; $display("FAIL postflush_idx got %0d/%0d want 5/6", bus0.ex_cm_robAIdx, bus0.ex_cm_robBIdx); end
  endtask

  task automatic test_back_to_back;
    int         run;
    int         nxt;
    logic [3:0] g;
    run = 0;
    nxt = 0;
    flush_both();
    bus0.fu_req = 4'hF;
    for (int k = 0; k < 16; k++) begin
      g = k[0] ? 4'b1100 : 4'b0011;
      for (int i = 0; i < 4; i++)
        load0(i, 5'(k[0] == i[1] ? 2 * k + i[0] : 31), 6'(k), 64'(k));
      #1;
      checks++; if (bus0.fu_grant !== g) begin errors++; $display("FAIL b2b_grant k%0d got %b want %b", k, bus0.fu_grant, g); end
      step();
      checks++; if (bus0.ex_cm_robAIdx !== 5'(nxt) || bus0.ex_cm_robBIdx !== 5'(nxt + 1)) begin errors++; $display("FAIL b2b_order k%0d got %0d/%0d want %0d/%0d", k, bus0.ex_cm_robAIdx, bus0.ex_cm_robBIdx, nxt, nxt + 1); end
      if (bus0.ex_cm_cdbA_rdy === 1'b1 && bus0.ex_cm_cdbB_rdy === 1'b1) run++;
      nxt += 2;
    end
    bus0.fu_req = '0;
    checks++; if (run !== 16) begin errors++; $display("FAIL b2b_run got %0d want 16", run); end
    step();
    checks++; if (bus0.ex_cm_cdbA_rdy !== 1'b0 || bus0.ex_cm_cdbB_rdy !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b%b want 00", bus0.ex_cm_cdbA_rdy, bus0.ex_cm_cdbB_rdy); end
  endtask

  initial begin
    reset          = 1'b0;
    bus0.flush     = 1'b0;
    bus1.flush     = 1'b0;
    bus0.fu_req    = '0;
    bus1.fu_req    = '0;
    bus0.fu_robidx = '0;
    bus1.fu_robidx = '0;
    bus0.fu_tag    = '0;
    bus1.fu_tag    = '0;
    bus0.fu_data   = '0;
    bus1.fu_data   = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_nostall();
    test_flush();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
